// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and types for the pipeline stage registers
package pipe_pkg;

  localparam int EXC_W_DEFAULT = 5;

  // MIPS CP0 cause codes carried through the pipeline
  localparam logic [4:0] EXC_NONE    = 5'd0;
  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;
  localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;

  // What a stage register does on a given edge (reset is handled separately)
  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_STALL  = 2'd2,
    ACT_REQ    = 2'd3
  } stage_act_e;

endpackage

// File: rtl/pipe_exc_merge.sv
// rtl/pipe_exc_merge.sv - merges carried and stage-local exception codes
module pipe_exc_merge
  import pipe_pkg::*;
#(
  parameter int EXC_W = EXC_W_DEFAULT
) (
  input  logic [EXC_W-1:0] excCode_in,
  input  logic [EXC_W-1:0] exc_local,
  input  logic             valid_in,
  output logic [EXC_W-1:0] merged
);

  // Earlier-stage exception wins; a non-instruction slot never carries one.
  always_comb begin
    merged = '0;
    if (valid_in) begin
      if (excCode_in != '0) merged = excCode_in;
      else                  merged = exc_local;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - generic inter-stage register with hold, bubble and exception flush
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          DATA_W            = 64,
  parameter int          EXC_W             = EXC_W_DEFAULT,
  parameter logic [31:0] HANDLER_PC        = HANDLER_PC_DEFAULT,
  parameter bit          KEEP_PC_ON_BUBBLE = 1'b1,
  parameter int          CNT_W             = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              stall,
  input  logic              bubble,
  input  logic              valid_in,
  input  logic [31:0]       instr_in,
  input  logic [31:0]       pc_in,
  input  logic              bd_in,
  input  logic [EXC_W-1:0]  excCode_in,
  input  logic [EXC_W-1:0]  exc_local,
  input  logic [DATA_W-1:0] payload_in,
  output logic              valid_out,
  output logic [31:0]       instr_out,
  output logic [31:0]       pc_out,
  output logic              bd_out,
  output logic [EXC_W-1:0]  excCode_out,
  output logic [DATA_W-1:0] payload_out,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [EXC_W-1:0] exc_merged;
  stage_act_e       act;

  pipe_exc_merge #(
    .EXC_W (EXC_W)
  ) u_exc_merge (
    .excCode_in (excCode_in),
    .exc_local  (exc_local),
    .valid_in   (valid_in),
    .merged     (exc_merged)
  );

  // Pick this edge's action: req beats stall, stall beats bubble.
  always_comb begin
    act = ACT_LOAD;
    if (req)         act = ACT_REQ;
    else if (stall)  act = ACT_STALL;
    else if (bubble) act = ACT_BUBBLE;
  end

  // Stage register; a stall leaves every field untouched and only counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out   <= 1'b0;
      instr_out   <= NOP_INSTR;
      pc_out      <= '0;
      bd_out      <= 1'b0;
      excCode_out <= '0;
      payload_out <= '0;
      stall_cnt   <= '0;
    end else begin
      case (act)
        ACT_REQ: begin
          valid_out   <= 1'b0;
          instr_out   <= NOP_INSTR;
          pc_out      <= HANDLER_PC;
          bd_out      <= 1'b0;
          excCode_out <= '0;
          payload_out <= '0;
          stall_cnt   <= '0;
        end
        ACT_STALL: begin
          if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
        end
        ACT_BUBBLE: begin
          valid_out   <= 1'b0;
          instr_out   <= NOP_INSTR;
          excCode_out <= '0;
          payload_out <= '0;
          stall_cnt   <= '0;
          // Keeping pc/bd lets CP0 report a sane EPC/BD if an interrupt hits the bubble
          pc_out      <= KEEP_PC_ON_BUBBLE ? pc_in : 32'h0;
          bd_out      <= KEEP_PC_ON_BUBBLE ? bd_in : 1'b0;
        end
        default: begin
          valid_out   <= valid_in;
          instr_out   <= instr_in;
          pc_out      <= pc_in;
          bd_out      <= bd_in;
          excCode_out <= exc_merged;
          payload_out <= payload_in;
          stall_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset, req, stall, bubble, valid_in, bd_in;
  logic [31:0] instr_in, pc_in;
  logic [4:0]  excCode_in, exc_local;
  logic [63:0] payload_in;

  logic        valid_out, bd_out;
  logic [31:0] instr_out, pc_out;
  logic [4:0]  excCode_out;
  logic [63:0] payload_out;
  logic [3:0]  stall_cnt;

  logic        valid_nk, bd_nk;
  logic [31:0] instr_nk, pc_nk;
  logic [4:0]  exc_nk;
  logic [63:0] payload_nk;
  logic [3:0]  cnt_nk;

  logic        valid_hp, bd_hp;
  logic [31:0] instr_hp, pc_hp;
  logic [4:0]  exc_hp;
  logic [63:0] payload_hp;
  logic [3:0]  cnt_hp;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg u_dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .bubble(bubble),
    .valid_in(valid_in), .instr_in(instr_in), .pc_in(pc_in), .bd_in(bd_in),
    .excCode_in(excCode_in), .exc_local(exc_local), .payload_in(payload_in),
    .valid_out(valid_out), .instr_out(instr_out), .pc_out(pc_out), .bd_out(bd_out),
    .excCode_out(excCode_out), .payload_out(payload_out), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.KEEP_PC_ON_BUBBLE(1'b0)) u_dut_nokeep (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .bubble(bubble),
    .valid_in(valid_in), .instr_in(instr_in), .pc_in(pc_in), .bd_in(bd_in),
    .excCode_in(excCode_in), .exc_local(exc_local), .payload_in(payload_in),
    .valid_out(valid_nk), .instr_out(instr_nk), .pc_out(pc_nk), .bd_out(bd_nk),
    .excCode_out(exc_nk), .payload_out(payload_nk), .stall_cnt(cnt_nk)
  );

  pipe_stage_reg #(.HANDLER_PC(32'h8000_0180)) u_dut_hpc (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .bubble(bubble),
    .valid_in(valid_in), .instr_in(instr_in), .pc_in(pc_in), .bd_in(bd_in),
    .excCode_in(excCode_in), .exc_local(exc_local), .payload_in(payload_in),
    .valid_out(valid_hp), .instr_out(instr_hp), .pc_out(pc_hp), .bd_out(bd_hp),
    .excCode_out(exc_hp), .payload_out(payload_hp), .stall_cnt(cnt_hp)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic bd, input logic [4:0] ec, input logic [4:0] el,
                      input logic [63:0] pl);
    valid_in = v; instr_in = ins; pc_in = pc; bd_in = bd;
    excCode_in = ec; exc_local = el; payload_in = pl;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_valid"},   valid_out,   0);
    check_eq({tag, "_instr"},   instr_out,   0);
    check_eq({tag, "_pc"},      pc_out,      0);
    check_eq({tag, "_bd"},      bd_out,      0);
    check_eq({tag, "_exc"},     excCode_out, 0);
    check_eq({tag, "_payload"}, payload_out, 0);
    check_eq({tag, "_cnt"},     stall_cnt,   0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset with junk inputs
    reset = 1; req = 0; stall = 0; bubble = 0;
    load(1, 32'hdead_beef, 32'h1234, 1, 5'd3, 5'd7, 64'hffff_0000_1234_5678);
    step(); step();
    check_zero("reset");

    reset = 0;
    load(1, 32'h2408_0001, 32'h3000, 0, 0, 0, 64'h11);
    step();
    check_eq("first_pc",    pc_out,    32'h3000);
    check_eq("first_valid", valid_out, 1);
    check_eq("first_instr", instr_out, 32'h2408_0001);
    check_eq("first_pay",   payload_out, 64'h11);
    check_eq("first_exc",   excCode_out, 0);

    // 2. exception merge
    load(1, 32'h1, 32'h3004, 0, 5'd0, 5'd12, 64'h22);
    step();
    check_eq("merge_local", excCode_out, 12);
    load(1, 32'h2, 32'h3008, 0, 5'd4, 5'd12, 64'h33);
    step();
    check_eq("merge_prior", excCode_out, 4);
    load(0, 32'h3, 32'h300c, 1, 5'd0, 5'd10, 64'h44);
    step();
    check_eq("merge_inval_exc", excCode_out, 0);
    check_eq("merge_inval_v",   valid_out, 0);
    check_eq("merge_inval_pc",  pc_out, 32'h300c);
    check_eq("merge_inval_bd",  bd_out, 1);

    // 3 + 6a. stall with changing inputs, bubble toggling underneath
    load(1, 32'haaaa_5555, 32'h3100, 1, 5'd8, 5'd0, 64'hcafe);
    step();
    stall = 1;
    for (int i = 0; i < 20; i++) begin
      bubble = i[0];
      load(i[1], 32'h100 + i, 32'h4000 + 4 * i, 0, 5'd0, 5'd5, 64'(i));
      step();
      check_eq("stall_pc",    pc_out,      32'h3100);
      check_eq("stall_instr", instr_out,   32'haaaa_5555);
      check_eq("stall_valid", valid_out,   1);
      check_eq("stall_exc",   excCode_out, 8);
      check_eq("stall_cnt",   stall_cnt,   (i + 1 > 15) ? 15 : i + 1);
    end
    check_eq("stall_pay", payload_out, 64'hcafe);
    stall = 0; bubble = 0;
    load(1, 32'hbbbb_0000, 32'h3200, 0, 0, 0, 64'h77);
    step();
    check_eq("unstall_cnt", stall_cnt, 0);
    check_eq("unstall_pc",  pc_out, 32'h3200);
    check_eq("unstall_ins", instr_out, 32'hbbbb_0000);

    // 4. bubble, both pc policies
    bubble = 1;
    load(1, 32'hcccc_1111, 32'h3010, 1, 5'd4, 5'd12, 64'h99);
    step();
    check_eq("bub_instr", instr_out,   0);
    check_eq("bub_valid", valid_out,   0);
    check_eq("bub_pc",    pc_out,      32'h3010);
    check_eq("bub_bd",    bd_out,      1);
    check_eq("bub_exc",   excCode_out, 0);
    check_eq("bub_pay",   payload_out, 0);
    check_eq("bubnk_pc",  pc_nk,       0);
    check_eq("bubnk_bd",  bd_nk,       0);
    check_eq("bubnk_v",   valid_nk,    0);
    bubble = 0;

    // 5. req over stall and bubble
    load(1, 32'hdddd_2222, 32'h3300, 1, 5'd10, 0, 64'h55);
    step();
    stall = 1;
    step(); step(); step();
    check_eq("pre_req_cnt", stall_cnt, 3);
    req = 1; bubble = 1;
    step();
    check_eq("req_pc",    pc_out,      32'h0000_4180);
    check_eq("req_valid", valid_out,   0);
    check_eq("req_instr", instr_out,   0);
    check_eq("req_bd",    bd_out,      0);
    check_eq("req_exc",   excCode_out, 0);
    check_eq("req_pay",   payload_out, 0);
    check_eq("req_cnt",   stall_cnt,   0);
    check_eq("reqhp_pc",  pc_hp,       32'h8000_0180);
    check_eq("reqhp_cnt", cnt_hp,      0);
    req = 0; stall = 0; bubble = 0;

    // 6b. reset landing mid-stall
    load(1, 32'heeee_3333, 32'h3400, 1, 5'd5, 0, 64'h66);
    step();
    stall = 1;
    for (int i = 0; i < 7; i++) step();
    check_eq("rst_stall_cnt_pre", stall_cnt, 7);
    reset = 1;
    step();
    check_zero("rst_stall");
    reset = 0;
    step();
    check_eq("post_rst_cnt",   stall_cnt, 1);
    check_eq("post_rst_valid", valid_out, 0);
    stall = 0;
    load(1, 32'hffff_4444, 32'h3500, 0, 0, 5'd8, 64'h88);
    step();
    check_eq("post_rst_pc",  pc_out, 32'h3500);
    check_eq("post_rst_exc", excCode_out, 8);
    check_eq("post_rst_c0",  stall_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
